// File: rtl/traffic_phase_ctrl_if.sv
// Bundle between the sensor/push-button front end, the phase controller and the lamp drivers.
// The controller takes the slave side. A front end or testbench takes the master side.
`timescale 1ns/1ps
interface traffic_phase_ctrl_if #(
    parameter int N_APPR = 2
);
    logic                  ERR;
    logic [N_APPR-1:0]     PED;
    logic [3*N_APPR-1:0]   LIGHTS;
    logic [N_APPR-1:0]     WALK;
    logic [N_APPR-1:0]     PED_PEND;
    logic [2:0]            ACTIVE;
    logic                  FLASHING;

    modport master (
        output ERR, PED,
        input  LIGHTS, WALK, PED_PEND, ACTIVE, FLASHING
    );

    modport slave (
        input  ERR, PED,
        output LIGHTS, WALK, PED_PEND, ACTIVE, FLASHING
    );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// Round-robin N-approach phase sequencer: arrow, green, yellow and all-red per approach.
// It adds a pedestrian walk phase at the end of each round and a fault flash mode.
`timescale 1ns/1ps
module traffic_phase_ctrl #(
    parameter int N_APPR     = 2,
    parameter int CNT_W      = 8,
    parameter int ARROW_CYC  = 2,
    parameter int GREEN_CYC  = 7,
    parameter int YELLOW_CYC = 2,
    parameter int ALLRED_CYC = 1,
    parameter int WALK_CYC   = 5,
    parameter int FLASH_MODE = 0
) (
    input  logic                CLK,
    input  logic                reset,
    traffic_phase_ctrl_if.slave bus
);
    localparam logic [2:0] C_GREEN  = 3'b110;
    localparam logic [2:0] C_LARROW = 3'b101;
    localparam logic [2:0] C_YELLOW = 3'b100;
    localparam logic [2:0] C_RED    = 3'b011;
    localparam logic [2:0] C_FRED   = 3'b111;
    localparam logic [2:0] C_FYEL   = 3'b000;

    localparam logic [CNT_W-1:0] ARROW_LD  = CNT_W'(ARROW_CYC - 1);
    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_CYC - 1);
    localparam logic [CNT_W-1:0] WALK_LD   = CNT_W'(WALK_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [N_APPR-1:0] P_ZERO   = {N_APPR{1'b0}};
    localparam logic [2:0] LAST_A          = 3'(N_APPR - 1);

    typedef enum logic [2:0] {
        S_ALLRED = 3'd0,
        S_ARROW  = 3'd1,
        S_GREEN  = 3'd2,
        S_YELLOW = 3'd3,
        S_WALK   = 3'd4,
        S_FLASH  = 3'd5
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [2:0]          r_a, w_a_nxt;
    // After reset or a fault, the clearance phase restarts the round at approach 0.
    logic                r_restart, w_restart_nxt;
    logic [N_APPR-1:0]   r_req, w_req_nxt;
    logic [N_APPR-1:0]   r_mask, w_mask_nxt;
    logic [3*N_APPR-1:0] r_lights;
    logic [N_APPR-1:0]   r_walk;
    logic                r_flashing;
    logic                w_cnt_done;

    assign w_cnt_done = (r_cnt == CNT_ZERO);

    function automatic logic [3*N_APPR-1:0] f_lights(input state_t st, input logic [2:0] act);
        logic [3*N_APPR-1:0] v;
        v = {N_APPR{C_RED}};
        for (int i = 0; i < N_APPR; i++) begin
            case (st)
                S_ARROW:  v[3*i +: 3] = (act == 3'(i)) ? C_LARROW : C_RED;
                S_GREEN:  v[3*i +: 3] = (act == 3'(i)) ? C_GREEN  : C_RED;
                S_YELLOW: v[3*i +: 3] = (act == 3'(i)) ? C_YELLOW : C_RED;
                S_FLASH:  v[3*i +: 3] = ((FLASH_MODE == 1) && (i == 0)) ? C_FYEL : C_FRED;
                default:  v[3*i +: 3] = C_RED;
            endcase
        end
        return v;
    endfunction

    // Next-state, phase counter, approach index and pedestrian latch
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt - CNT_ONE;
        w_a_nxt       = r_a;
        w_restart_nxt = r_restart;
        w_mask_nxt    = r_mask;
        w_req_nxt     = r_req | bus.PED;
        if (bus.ERR) begin
            w_state_nxt   = S_FLASH;
            w_cnt_nxt     = CNT_ZERO;
            w_req_nxt     = P_ZERO;
            w_mask_nxt    = P_ZERO;
            w_restart_nxt = 1'b1;
        end else begin
            case (r_state)
                S_ARROW: begin
                    if (w_cnt_done) begin
                        w_state_nxt = S_GREEN;
                        w_cnt_nxt   = GREEN_LD;
                    end else begin
                        w_state_nxt = S_ARROW;
                    end
                end
                S_GREEN: begin
                    if (w_cnt_done) begin
                        w_state_nxt = S_YELLOW;
                        w_cnt_nxt   = YELLOW_LD;
                    end else begin
                        w_state_nxt = S_GREEN;
                    end
                end
                S_YELLOW: begin
                    if (w_cnt_done) begin
                        w_state_nxt = S_ALLRED;
                        w_cnt_nxt   = ALLRED_LD;
                    end else begin
                        w_state_nxt = S_YELLOW;
                    end
                end
                S_ALLRED: begin
                    if (w_cnt_done) begin
                        w_state_nxt = S_ARROW;
                        w_cnt_nxt   = ARROW_LD;
                        if (r_restart || ((r_a == LAST_A) && (r_req == P_ZERO))) begin
                            w_a_nxt       = 3'd0;
                            w_restart_nxt = 1'b0;
                        end else if (r_a == LAST_A) begin
                            w_state_nxt = S_WALK;
                            w_cnt_nxt   = WALK_LD;
                            w_mask_nxt  = r_req | bus.PED;
                            w_req_nxt   = P_ZERO;
                        end else begin
                            w_a_nxt = r_a + 3'd1;
                        end
                    end else begin
                        w_state_nxt = S_ALLRED;
                    end
                end
                S_WALK: begin
                    if (w_cnt_done) begin
                        w_state_nxt = S_ARROW;
                        w_cnt_nxt   = ARROW_LD;
                        w_a_nxt     = 3'd0;
                        w_mask_nxt  = P_ZERO;
                    end else begin
                        w_state_nxt = S_WALK;
                    end
                end
                S_FLASH: begin
                    w_state_nxt   = S_ALLRED;
                    w_cnt_nxt     = ALLRED_LD;
                    w_req_nxt     = r_req;
                    w_restart_nxt = 1'b1;
                end
                default: begin
                    w_state_nxt   = S_FLASH;
                    w_cnt_nxt     = CNT_ZERO;
                    w_req_nxt     = r_req;
                    w_mask_nxt    = P_ZERO;
                    w_restart_nxt = 1'b1;
                end
            endcase
        end
    end

    // State register with outputs decoded from the next state so they track the state
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state    <= S_ALLRED;
            r_cnt      <= ALLRED_LD;
            r_a        <= 3'd0;
            r_restart  <= 1'b1;
            r_req      <= P_ZERO;
            r_mask     <= P_ZERO;
            r_lights   <= {N_APPR{C_RED}};
            r_walk     <= P_ZERO;
            r_flashing <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_a        <= w_a_nxt;
            r_restart  <= w_restart_nxt;
            r_req      <= w_req_nxt;
            r_mask     <= w_mask_nxt;
            r_lights   <= f_lights(w_state_nxt, w_a_nxt);
            r_walk     <= (w_state_nxt == S_WALK) ? w_mask_nxt : P_ZERO;
            r_flashing <= (w_state_nxt == S_FLASH);
        end
    end

    assign bus.LIGHTS   = r_lights;
    assign bus.WALK     = r_walk;
    assign bus.PED_PEND = r_req;
    assign bus.ACTIVE   = r_a;
    assign bus.FLASHING = r_flashing;
endmodule

// File: doc/traffic_phase_ctrl.md
# traffic_phase_ctrl

Parametrised successor to the two-approach intersection controller. It sequences N_APPR approaches round-robin through left-arrow, green, yellow and all-red phases. Each phase has its own programmable length. Pedestrian requests are latched per approach and served in a dedicated all-red walk phase at the end of each round. An error input forces a configurable flashing mode. The block sits between the sensor/push-button front end and the lamp drivers.

## Interface
- N_APPR, 2, number of approaches served round-robin (2..8)
- CNT_W, 8, phase counter width
- ARROW_CYC, 2, left-arrow phase length in cycles (1..2^CNT_W)
- GREEN_CYC, 7, green phase length in cycles
- YELLOW_CYC, 2, yellow phase length in cycles
- ALLRED_CYC, 1, all-red clearance length in cycles
- WALK_CYC, 5, pedestrian walk phase length in cycles
- FLASH_MODE, 0, 0: all approaches flashing red; 1: approach 0 flashing yellow, others flashing red
- CLK  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- ERR  in  1  fault input, level-sensitive
- PED  in  N_APPR  pedestrian request per approach, 1-cycle pulse or level
- LIGHTS  out  3*N_APPR  lamp code per approach; approach i occupies bits [3i+2:3i]
- WALK  out  N_APPR  walk indication per approach
- PED_PEND  out  N_APPR  latched, not-yet-served requests
- ACTIVE  out  3  index of the approach currently holding right-of-way
- FLASHING  out  1  high while in FLASH state

## Operation
- Lamp codes: Green 110, GreenLeftArrow 101, Yellow 100, Red 011, GreenRightArrow 010, FlashingRed 111, FlashingYellow 000.
- States: ALLRED, ARROW, GREEN, YELLOW, WALK, FLASH. There is also an approach index `a` (0..N_APPR-1).
- Sequence: ARROW(a) → GREEN(a) → YELLOW(a) → ALLRED.
  - Leaving ALLRED with a<N_APPR-1: a increments and the block enters ARROW.
  - Leaving ALLRED with a=N_APPR-1: if any request is pending, enter WALK; otherwise a=0 and enter ARROW.
  - WALK → ARROW with a=0.
- Lamp drive:
  - Active approach: ARROW 101, GREEN 110, YELLOW 100.
  - All non-active approaches: 011.
  - ALLRED and WALK: every approach 011.
- Pedestrian latch:
  - req[i] is set by PED[i] in any state except FLASH.
  - On WALK entry, walk_mask = req | PED and req is cleared.
  - PED arriving during WALK sets req for the next round.
- WALK = walk_mask during WALK, else 0. PED_PEND = req.
- Fault handling:
  - ERR=1 in any state: next state is FLASH, req and walk_mask are cleared, and ACTIVE is held.
  - While in FLASH, lamps follow FLASH_MODE.
  - ERR deasserts: ALLRED for ALLRED_CYC cycles, then ARROW with a=0.
- Priority: reset > ERR > normal sequencing.
- Illegal state encoding recovers to FLASH for one cycle, then follows the ERR=0 path.

## Timing
- All outputs are registered and reflect the current state; no combinational path from inputs to outputs.
- Phase counter behaviour:
  - Loads (length-1) on phase entry and decrements each cycle.
  - The state advances on the cycle after the counter reads 0.
  - Each phase therefore lasts exactly its parameter length in cycles.
- Reset values (cycle after reset sampled high):
  - State ALLRED, counter ALLRED_CYC-1, a=0.
  - LIGHTS all 011, WALK 0, PED_PEND 0, ACTIVE 0, FLASHING 0.
- ERR is sampled on an edge. LIGHTS shows flash codes and FLASHING=1 from the next cycle (1-cycle latency).
- PED is sampled on an edge. PED_PEND rises the next cycle.
- A PED pulse coincident with WALK entry is served in that WALK, not deferred.
- reset mid-phase aborts immediately, with no yellow or clearance first.
- Full round without walk = N_APPR*(ARROW_CYC+GREEN_CYC+YELLOW_CYC+ALLRED_CYC) cycles.

## Test plan
- **Reset then run:** reset 2 cycles, N_APPR=2, defaults → LIGHTS[2:0] shows 101×2, 110×7, 100×2, all-red×1 while LIGHTS[5:3]=011; approach 1 then follows identically. Round = 24 cycles.
- **Pedestrian request:** PED=2'b10 pulse at cycle 5 → PED_PEND=10 at cycle 6. After approach 1 ALLRED, WALK=10 for 5 cycles with all lamps 011. PED_PEND clears on WALK entry, then ARROW(0).
- **Request during walk:** PED[0] pulse during WALK → not in the current WALK; PED_PEND=01 persists and is served at the end of the next round.
- **Fault mid-green:** ERR high at cycle 10 → cycle 11 shows LIGHTS=111111 and FLASHING=1. With FLASH_MODE=1, LIGHTS=111000. ERR low → 1 cycle all-red, then ARROW(0); a pending PED is discarded.
- **Reset/ERR priority:** reset and ERR high together → ALLRED reset values, not FLASH. Reset during WALK → WALK=0 the next cycle.
- **Scaling:** N_APPR=4, GREEN_CYC=1, ARROW_CYC=1 → ACTIVE steps 0,1,2,3,0. Every phase has exact length, and exactly one approach is non-red at a time.
